// File: rtl/timed_lamp_sequencer.sv
// timed_lamp_sequencer: rotates N_CH lamp channels through
// ALLRED -> GREEN -> YELLOW with programmable dwell times. It also supports a
// hold (enable), a flashing-yellow override and a one-cycle phase-start strobe.
// All outputs are registered. They are decoded from the next-state values, so
// they always match the registered state (Moore behaviour).
module timed_lamp_sequencer #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 8,
  parameter int ALLRED_T = 2,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int FLASH_T  = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      flash_mode,
  output logic [3*N_CH-1:0]         light,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic                      phase_start,
  output logic                      in_flash
);

  localparam int CH_W = $clog2(N_CH);

  // Each timer reload value is "dwell minus one", so a phase lasts exactly T cycles.
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic               blink_q, blink_d;
  logic [3*N_CH-1:0]  light_q, light_d;
  logic               phase_start_q, phase_start_d;
  logic               in_flash_q, in_flash_d;

  // Lamp pattern for a given state. Only the owning channel may leave red.
  function automatic logic [3*N_CH-1:0] decode_light(
    input state_e          st,
    input logic [CH_W-1:0] ch,
    input logic            blink
  );
    logic [3*N_CH-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
      case (st)
        ST_ALLRED: v[3*c +: 3] = LAMP_RED;
        ST_GREEN:  v[3*c +: 3] = (ch == CH_W'(c)) ? LAMP_GREEN : LAMP_RED;
        ST_YELLOW: v[3*c +: 3] = (ch == CH_W'(c)) ? LAMP_YELLOW : LAMP_RED;
        ST_FLASH:  v[3*c +: 3] = blink ? LAMP_YELLOW : LAMP_OFF;
        default:   v[3*c +: 3] = LAMP_RED;
      endcase
    end
    return v;
  endfunction

  // Next-state logic. Priority is flash override, then leaving flash, then the timed sequence.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    tmr_d         = tmr_q;
    blink_d       = blink_q;
    phase_start_d = 1'b0;

    if (flash_mode) begin
      if (state_q != ST_FLASH) begin
        state_d       = ST_FLASH;
        blink_d       = 1'b1;
        tmr_d         = FLASH_LD;
        phase_start_d = 1'b1;
      end else if (tmr_q == '0) begin
        // Blink half-period elapsed. Toggling the blink is not treated as a new phase.
        blink_d = ~blink_q;
        tmr_d   = FLASH_LD;
      end else begin
        tmr_d = tmr_q - CNT_W'(1);
      end
    end else if (state_q == ST_FLASH) begin
      // Leaving flash always restarts the sequence cleanly from channel 0.
      state_d       = ST_ALLRED;
      ch_d          = CH_W'(0);
      tmr_d         = ALLRED_LD;
      blink_d       = 1'b0;
      phase_start_d = 1'b1;
    end else if (enable) begin
      if (tmr_q != '0) begin
        tmr_d = tmr_q - CNT_W'(1);
      end else begin
        phase_start_d = 1'b1;
        case (state_q)
          ST_ALLRED: begin
            state_d = ST_GREEN;
            tmr_d   = GREEN_LD;
          end
          ST_GREEN: begin
            state_d = ST_YELLOW;
            tmr_d   = YELLOW_LD;
          end
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            tmr_d   = ALLRED_LD;
            ch_d    = (ch_q == LAST_CH) ? CH_W'(0) : ch_q + CH_W'(1);
          end
          default: begin
            state_d = ST_ALLRED;
            tmr_d   = ALLRED_LD;
            ch_d    = CH_W'(0);
          end
        endcase
      end
    end else begin
      // Hold: every register keeps its value, and no new phase starts.
      phase_start_d = 1'b0;
    end

    light_d    = decode_light(state_d, ch_d, blink_d);
    in_flash_d = (state_d == ST_FLASH);
  end

  // State, timer and output registers. The reset is synchronous and active-low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_ALLRED;
      ch_q          <= CH_W'(0);
      tmr_q         <= ALLRED_LD;
      blink_q       <= 1'b0;
      light_q       <= {N_CH{LAMP_RED}};
      phase_start_q <= 1'b1;
      in_flash_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      tmr_q         <= tmr_d;
      blink_q       <= blink_d;
      light_q       <= light_d;
      phase_start_q <= phase_start_d;
      in_flash_q    <= in_flash_d;
    end
  end

  assign light       = light_q;
  assign active_ch   = ch_q;
  assign phase_start = phase_start_q;
  assign in_flash    = in_flash_q;

endmodule

// File: tb/tb_timed_lamp_sequencer.sv
// Directed bench for timed_lamp_sequencer. The main instance uses
// N_CH=3 with dwell times 2/5/3/2. A second instance uses N_CH=2 and every
// dwell set to 1, so it changes phase on every cycle.
module tb_timed_lamp_sequencer;

  logic       clock = 1'b0;
  logic       reset_n, enable, flash_mode;
  logic [8:0] light;
  logic [1:0] active_ch;
  logic       phase_start, in_flash;

  logic       rst2_n, en2, flash2;
  logic [5:0] light2;
  logic [0:0] ach2;
  logic       ps2, fl2;

  int n_vec = 0;
  int n_err = 0;
  int ps_cnt = 0;

  always #5 clock = ~clock;

  timed_lamp_sequencer #(
    .N_CH(3), .CNT_W(8), .ALLRED_T(2), .GREEN_T(5), .YELLOW_T(3), .FLASH_T(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flash_mode(flash_mode),
    .light(light), .active_ch(active_ch), .phase_start(phase_start), .in_flash(in_flash)
  );

  timed_lamp_sequencer #(
    .N_CH(2), .CNT_W(8), .ALLRED_T(1), .GREEN_T(1), .YELLOW_T(1), .FLASH_T(1)
  ) dut_t1 (
    .clock(clock), .reset_n(rst2_n), .enable(en2), .flash_mode(flash2),
    .light(light2), .active_ch(ach2), .phase_start(ps2), .in_flash(fl2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ph: 0 all-red, 1 green on ch, 2 yellow on ch, 3 flash lit, 4 flash dark
  function automatic logic [31:0] exp_light(input int n, input int ph, input int ch);
    logic [31:0] r;
    logic [2:0]  lamp;
    r = 32'd0;
    for (int c = 0; c < n; c++) begin
      case (ph)
        1:       lamp = (c == ch) ? 3'b010 : 3'b100;
        2:       lamp = (c == ch) ? 3'b001 : 3'b100;
        3:       lamp = 3'b001;
        4:       lamp = 3'b000;
        default: lamp = 3'b100;
      endcase
      r = r | (32'(lamp) << (3 * c));
    end
    return r;
  endfunction

  task automatic cyc(input string tag, input int ph, input int ch, input logic ps,
                     input logic fl, input logic chk_ch);
    @(negedge clock);
    check_eq({tag, "/light"}, 32'(light), exp_light(3, ph, ch));
    if (chk_ch) check_eq({tag, "/active_ch"}, 32'(active_ch), 32'(ch));
    check_eq({tag, "/phase_start"}, 32'(phase_start), 32'(ps));
    check_eq({tag, "/in_flash"}, 32'(in_flash), 32'(fl));
    if (phase_start) ps_cnt++;
  endtask

  // Normal rotation. The period is 30 cycles and each channel owns 10:
  // offsets 0-1 are all-red, 2-6 green and 7-9 yellow.
  task automatic run_norm(input int q0, input int n);
    int q, c, o, ph;
    logic ps;
    for (int i = 0; i < n; i++) begin
      q  = (q0 + i) % 30;
      c  = q / 10;
      o  = q % 10;
      ph = (o < 2) ? 0 : ((o < 7) ? 1 : 2);
      ps = (o == 0 || o == 2 || o == 7);
      cyc($sformatf("norm_q%0d", q), ph, c, ps, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int m, nonred;
    reset_n = 1'b0; enable = 1'b1; flash_mode = 1'b0;
    rst2_n = 1'b0; en2 = 1'b1; flash2 = 1'b0;
    repeat (3) @(posedge clock);

    // The reset state is the first all-red cycle.
    run_norm(0, 1);
    reset_n = 1'b1;
    ps_cnt = 0;
    run_norm(1, 30);
    check_eq("ps_per_period", 32'(ps_cnt), 32'd9);

    // Hold for 7 cycles in ch1 green with the timer at 2.
    run_norm(1, 14);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) cyc("hold", 1, 1, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    cyc("regreen1", 1, 1, 1'b0, 1'b0, 1'b1);
    cyc("regreen2", 1, 1, 1'b0, 1'b0, 1'b1);
    cyc("yel_after_hold", 2, 1, 1'b1, 1'b0, 1'b1);
    run_norm(18, 5);

    // Flash entered from ch2 green.
    flash_mode = 1'b1;
    cyc("fl_on1", 3, 0, 1'b1, 1'b1, 1'b0);
    cyc("fl_on2", 3, 0, 1'b0, 1'b1, 1'b0);
    cyc("fl_off1", 4, 0, 1'b0, 1'b1, 1'b0);
    cyc("fl_off2", 4, 0, 1'b0, 1'b1, 1'b0);
    cyc("fl_on3", 3, 0, 1'b0, 1'b1, 1'b0);
    cyc("fl_on4", 3, 0, 1'b0, 1'b1, 1'b0);
    flash_mode = 1'b0;
    run_norm(0, 3);

    // Flash entered while enable is low.
    enable = 1'b0; flash_mode = 1'b1;
    cyc("fle_on1", 3, 0, 1'b1, 1'b1, 1'b0);
    cyc("fle_on2", 3, 0, 1'b0, 1'b1, 1'b0);
    cyc("fle_off1", 4, 0, 1'b0, 1'b1, 1'b0);
    cyc("fle_off2", 4, 0, 1'b0, 1'b1, 1'b0);
    cyc("fle_on3", 3, 0, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-flash.
    reset_n = 1'b0; flash_mode = 1'b0; enable = 1'b1;
    run_norm(0, 1);
    reset_n = 1'b1;
    run_norm(1, 18);

    // Reset asserted mid-yellow on ch1.
    reset_n = 1'b0;
    run_norm(0, 1);
    reset_n = 1'b1;
    run_norm(1, 12);

    // Instance with every dwell set to 1: the phase changes on every cycle.
    @(negedge clock);
    check_eq("t1_rst/light", 32'(light2), 32'h24);
    check_eq("t1_rst/phase_start", 32'(ps2), 32'd1);
    check_eq("t1_rst/in_flash", 32'(fl2), 32'd0);
    rst2_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      m = k % 6;
      check_eq($sformatf("t1_k%0d/light", k), 32'(light2), exp_light(2, m % 3, m / 3));
      check_eq($sformatf("t1_k%0d/active_ch", k), 32'(ach2), 32'(m / 3));
      check_eq($sformatf("t1_k%0d/phase_start", k), 32'(ps2), 32'd1);
      nonred = 0;
      for (int c = 0; c < 2; c++) if (light2[3*c +: 3] != 3'b100) nonred++;
      check_eq($sformatf("t1_k%0d/single_nonred", k), 32'(nonred <= 1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
